// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM state encoding and
// the bytes-per-instruction helper used to step and align the fetch PC.
package fetch_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    function automatic int instr_bytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/if_prefetch_queue.sv
// Prefetching IF stage: pipelined IMEM requests into a DEPTH-entry circular
// queue, valid/ready handoff to ID, redirect flush with stale-response discard.
module if_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] boot_add,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_add_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_instr_o,
    output logic [ADDR_WIDTH-1:0] if_pc_o,
    input  logic                  id_ready_i
);

    localparam int INSTR_BYTES = instr_bytes(DATA_WIDTH);
    localparam int IW          = $clog2(DEPTH);
    localparam int PW          = IW + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
        logic                  filled;
    } entry_t;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("if_prefetch_queue: DEPTH must be a power of two >= 2");
        end
    endgenerate

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]         alloc_q, alloc_d;
    logic [PW-1:0]         fill_q, fill_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [PW-1:0]         discard_q, discard_d;
    entry_t                entries_q [DEPTH];
    entry_t                entries_d [DEPTH];

    logic [PW-1:0] occupancy;
    logic [PW:0]   committed;
    logic          issue;
    logic          pop;
    entry_t        head;

    // Queue slots plus responses still owed to flushed requests bound the
    // number of IMEM transactions in flight.
    assign occupancy  = alloc_q - rd_q;
    assign committed  = {1'b0, occupancy} + {1'b0, discard_q};
    assign imem_req_o = (state_q == RUN) && !redirect_i && (committed < (PW+1)'(DEPTH));
    assign imem_add_o = pc_q & ALIGN_MASK;
    assign issue      = imem_req_o && imem_gnt_i;

    assign head       = entries_q[rd_q[IW-1:0]];
    assign if_valid_o = (occupancy != '0) && head.filled;
    assign if_instr_o = head.instr;
    assign if_pc_o    = head.pc;
    assign pop        = if_valid_o && id_ready_i;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        alloc_d   = alloc_q;
        fill_d    = fill_q;
        rd_d      = rd_q;
        discard_d = discard_q;
        entries_d = entries_q;

        if (state_q == BOOT) begin
            state_d = RUN;
            pc_d    = (redirect_i ? redirect_pc_i : boot_add) & ALIGN_MASK;
        end else if (redirect_i) begin
            // Every request not yet answered becomes stale; a response landing
            // this cycle is consumed here, so it leaves the count.
            alloc_d   = '0;
            fill_d    = '0;
            rd_d      = '0;
            pc_d      = redirect_pc_i & ALIGN_MASK;
            discard_d = discard_q + (alloc_q - fill_q) - PW'(imem_rvalid_i);
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].filled = 1'b0;
            end
        end else begin
            if (imem_rvalid_i) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - PW'(1);
                end else begin
                    entries_d[fill_q[IW-1:0]].instr  = imem_rdata_i;
                    entries_d[fill_q[IW-1:0]].filled = 1'b1;
                    fill_d = fill_q + PW'(1);
                end
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            // alloc slot never aliases fill slot here: that needs a full queue,
            // which already blocks issue.
            if (issue) begin
                entries_d[alloc_q[IW-1:0]].pc     = pc_q & ALIGN_MASK;
                entries_d[alloc_q[IW-1:0]].filled = 1'b0;
                alloc_d = alloc_q + PW'(1);
                pc_d    = pc_q + ADDR_WIDTH'(INSTR_BYTES);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= '0;
            alloc_q   <= '0;
            fill_q    <= '0;
            rd_q      <= '0;
            discard_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            alloc_q   <= alloc_d;
            fill_q    <= fill_d;
            rd_q      <= rd_d;
            discard_q <= discard_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomised bench for if_prefetch_queue: an in-order variable-latency IMEM
// plus a queue-level reference of what ID and IMEM should see each cycle.
module tb_if_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] boot_add = 32'h0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        imem_req_o;
    logic [31:0] imem_add_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        id_ready_i = 1'b0;

    if_prefetch_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .boot_add(boot_add),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_req_o(imem_req_o), .imem_add_o(imem_add_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
        .id_ready_i(id_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } qe_t;
    typedef struct { logic [31:0] addr; int due; bit stale; } fl_t;

    qe_t mq[$];          // what ID should eventually see, oldest first
    fl_t fq[$];          // IMEM transactions in flight, issue order
    bit          boot_m;
    logic [31:0] pc_m;
    int          cyc = 0;

    int checks = 0;
    int errors = 0;

    int gnt_pct, rdy_pct, redir_pct, lat_min, lat_max;
    bit          force_redir = 0;
    logic [31:0] force_pc = 0;

    logic        obs_req, obs_valid;
    logic [31:0] obs_add, obs_pc, obs_instr;
    int          dut_pops = 0;
    int          wait_n;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (fq[i]) if (fq[i].stale) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        bit          exp_req, exp_valid, rv, do_pop;
        int          idx;
        fl_t         e;
        logic [31:0] rpc;

        imem_gnt_i = ($urandom_range(99) < gnt_pct);
        id_ready_i = ($urandom_range(99) < rdy_pct);
        redirect_i = force_redir || ($urandom_range(99) < redir_pct);
        rpc = force_redir ? force_pc
                          : (32'h0000_3000 + ($urandom_range(255) << 2) + $urandom_range(3));
        redirect_pc_i = rpc;
        rv = (fq.size() > 0) && (fq[0].due <= cyc);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_of(fq[0].addr) : $urandom;
        #1;
        obs_req = imem_req_o; obs_add = imem_add_o; obs_valid = if_valid_o;
        obs_pc = if_pc_o; obs_instr = if_instr_o;
        if (obs_valid && id_ready_i) dut_pops++;

        exp_req   = !boot_m && !redirect_i && (mq.size() + stale_cnt() < DEPTH);
        exp_valid = (mq.size() > 0) && mq[0].filled;
        chk("imem_req", {31'b0, obs_req}, {31'b0, exp_req});
        chk("imem_add", obs_add, pc_m);
        chk("if_valid", {31'b0, obs_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            chk("if_pc", obs_pc, mq[0].pc);
            chk("if_instr", obs_instr, mq[0].instr);
        end

        if (boot_m) begin
            pc_m = (redirect_i ? rpc : boot_add) & ~32'h3;
            boot_m = 0;
        end else if (redirect_i) begin
            if (rv) void'(fq.pop_front());
            foreach (fq[i]) fq[i].stale = 1;
            mq.delete();
            pc_m = rpc & ~32'h3;
        end else begin
            do_pop = exp_valid && id_ready_i;
            if (rv) begin
                e = fq.pop_front();
                if (!e.stale) begin
                    idx = -1;
                    foreach (mq[i]) if (idx < 0 && !mq[i].filled) idx = i;
                    if (idx >= 0) begin
                        mq[idx].instr = mem_of(e.addr);
                        mq[idx].filled = 1;
                    end
                end
            end
            if (do_pop) void'(mq.pop_front());
            if (exp_req && imem_gnt_i) begin
                mq.push_back('{pc: pc_m, instr: 32'h0, filled: 0});
                fq.push_back('{addr: pc_m, due: cyc + $urandom_range(lat_max, lat_min), stale: 0});
                pc_m = pc_m + 32'd4;
            end
        end
        force_redir = 0;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        boot_m = 1; pc_m = 32'h0;
        mq.delete(); fq.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   {31'b0, imem_req_o}, 32'h0);
        chk({tag, "_add"},   imem_add_o, 32'h0);
        chk({tag, "_valid"}, {31'b0, if_valid_o}, 32'h0);
        chk({tag, "_instr"}, if_instr_o, 32'h0);
        chk({tag, "_pc"},    if_pc_o, 32'h0);
    endtask

    task automatic knobs(input int g, input int r, input int rd, input int lmin, input int lmax);
        gnt_pct = g; rdy_pct = r; redir_pct = rd; lat_min = lmin; lat_max = lmax;
    endtask

    initial begin
        // Power-on reset, boot at 0x1000 with a one-cycle IMEM.
        model_reset();
        knobs(100, 100, 0, 1, 1);
        boot_add = 32'h0000_1000;
        #1;
        chk_all_zero("por");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("boot_first_req", {31'b0, obs_req}, 32'h1);
        chk("boot_first_add", obs_add, 32'h0000_1000);
        repeat (3) step();
        dut_pops = 0;
        repeat (20) step();
        chk("sustained_pops", dut_pops, 32'd20);

        // ID stall: queue fills, requests stop, nothing lost on resume.
        knobs(100, 0, 0, 1, 1);
        repeat (12) step();
        chk("stall_no_req", {31'b0, obs_req}, 32'h0);
        chk("stall_head_valid", {31'b0, obs_valid}, 32'h1);
        knobs(100, 100, 0, 1, 1);
        repeat (10) step();

        // Redirect coincident with response and pop.
        force_redir = 1; force_pc = 32'h0000_1800;
        step();
        step();
        chk("redir_rv_pop_valid", {31'b0, obs_valid}, 32'h0);
        chk("redir_rv_pop_add", obs_add, 32'h0000_1800);
        repeat (6) step();

        // Latency 3: redirect with requests in flight; their data is discarded.
        knobs(100, 100, 0, 3, 3);
        repeat (8) step();
        force_redir = 1; force_pc = 32'h0000_2000;
        step();
        wait_n = 0;
        step();
        while (!obs_valid && wait_n < 20) begin
            step();
            wait_n++;
        end
        chk("l3_redir_valid_seen", {31'b0, obs_valid}, 32'h1);
        chk("l3_redir_pc", obs_pc, 32'h0000_2000);
        chk("l3_redir_instr", obs_instr, mem_of(32'h0000_2000));

        // Address wrap from an unaligned redirect target near the top.
        knobs(100, 100, 0, 1, 1);
        force_redir = 1; force_pc = 32'hFFFF_FFFE;
        step();
        step();
        chk("wrap_add0", obs_add, 32'hFFFF_FFFC);
        step();
        chk("wrap_add1", obs_add, 32'h0000_0000);
        repeat (5) step();

        // Random mix of grants, stalls, latencies and redirects.
        knobs(70, 60, 5, 1, 4);
        repeat (500) step();
        knobs(50, 90, 2, 1, 6);
        repeat (300) step();

        // Fill the queue, then reset asynchronously in mid-cycle.
        knobs(100, 0, 0, 1, 1);
        repeat (10) step();
        chk("full_head_valid", {31'b0, obs_valid}, 32'h1);
        chk("full_no_req", {31'b0, obs_req}, 32'h0);
        #2;
        rst_n = 1'b0;
        redirect_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; id_ready_i = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        boot_add = 32'h0000_4000;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        knobs(100, 100, 0, 1, 2);
        step();
        chk("restart_boot_req", {31'b0, obs_req}, 32'h0);
        step();
        chk("restart_req", {31'b0, obs_req}, 32'h1);
        chk("restart_add", obs_add, 32'h0000_4000);
        knobs(80, 70, 3, 1, 3);
        repeat (200) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
